// File: rtl/mbinit_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbinit_sb_pkg
// Description : Shared sideband definitions for MBINIT: message codes,
//               transmit FSM state encoding and default message width.
// Revision    : 1.0 - initial release
// ============================================================================
package mbinit_sb_pkg;

  localparam int SB_MSG_WIDTH_DEF = 4;

  localparam logic [3:0] MSG_CAL_DONE_REQ  = 4'b0001;
  localparam logic [3:0] MSG_CAL_DONE_RESP = 4'b0010;

  // The state names what the lane is carrying in the current cycle.
  typedef enum logic [2:0] {
    SB_IDLE   = 3'd0,
    SB_START  = 3'd1,
    SB_DATA   = 3'd2,
    SB_PARITY = 3'd3,
    SB_GAP    = 3'd4
  } sb_state_t;

endpackage
`default_nettype wire

// File: rtl/sb_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : sb_rr_arbiter2
// Description : Two-way round-robin arbiter with per-requester arm bits.
//               A winner is disarmed until its valid is seen low, so a
//               level request held across the handshake is not resent.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_rr_arbiter2
  import mbinit_sb_pkg::*;
(
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       grant_en,
  input  logic [1:0] valid,
  input  logic [1:0] msg_nz,
  output logic       grant,
  output logic       grant_id
);

  logic [1:0] armed;
  logic       ptr;
  logic [1:0] eligible;

  assign eligible = valid & msg_nz & armed;

  // Pick a winner: a lone eligible requester wins, a tie goes to the pointer.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (grant_en) begin
      case (eligible)
        2'b01: begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end
        2'b10: begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end
        2'b11: begin
          grant    = 1'b1;
          grant_id = ptr;
        end
        default: begin
          grant    = 1'b0;
          grant_id = 1'b0;
        end
      endcase
    end
  end

  // Pointer moves away from each winner; arm bits clear on grant, set on valid low.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 2'b11;
      ptr   <= 1'b0;
    end else begin
      if (grant) begin
        ptr <= ~grant_id;
      end
      for (int i = 0; i < 2; i++) begin
        if (grant && (grant_id == 1'(i))) begin
          armed[i] <= 1'b0;
        end else if (!valid[i]) begin
          armed[i] <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mbinit_sb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mbinit_sb_tx_arbiter
// Description : MBINIT sideband transmit stage. Arbitrates the CAL initiator
//               and responder requests and serializes the winner as
//               start bit, message MSB first, even parity, then an idle gap.
//               Drives busy and the falling-edge-busy handshake pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mbinit_sb_tx_arbiter
  import mbinit_sb_pkg::*;
#(
  parameter int SB_MSG_WIDTH = SB_MSG_WIDTH_DEF,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    i_flush,
  input  logic [SB_MSG_WIDTH-1:0] i_req0_msg,
  input  logic                    i_req0_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_req1_msg,
  input  logic                    i_req1_valid,
  output logic                    o_sb_tx_bit,
  output logic                    o_sb_tx_frame,
  output logic                    o_busy_sideband,
  output logic                    o_falling_edge_busy,
  output logic                    o_grant_id
);

  localparam int CNT_W = (SB_MSG_WIDTH > 1) ? $clog2(SB_MSG_WIDTH) : 1;

  sb_state_t               state_q, state_d;
  logic [SB_MSG_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]              gap_cnt_q, gap_cnt_d;
  logic                    par_q, par_d;
  logic                    tx_bit_q, tx_bit_d;
  logic                    frame_q, frame_d;
  logic                    busy_q, busy_d;
  logic                    fe_q, fe_d;
  logic                    gid_q, gid_d;

  logic                    arb_grant;
  logic                    arb_gid;
  logic                    grant_en;
  logic [SB_MSG_WIDTH-1:0] win_msg;

  // Grants only happen from IDLE, and a flush in IDLE suppresses them.
  assign grant_en = (state_q == SB_IDLE) && !i_flush;
  assign win_msg  = arb_gid ? i_req1_msg : i_req0_msg;

  sb_rr_arbiter2 u_arb (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .grant_en (grant_en),
    .valid    ({i_req1_valid, i_req0_valid}),
    .msg_nz   ({|i_req1_msg, |i_req0_msg}),
    .grant    (arb_grant),
    .grant_id (arb_gid)
  );

  // Next state and next lane values; every output is registered from these.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    par_d     = par_q;
    tx_bit_d  = 1'b0;
    frame_d   = 1'b0;
    busy_d    = busy_q;
    fe_d      = 1'b0;
    gid_d     = gid_q;

    if (i_flush && (state_q != SB_IDLE)) begin
      // Abort drops the lane without the handshake pulse.
      state_d = SB_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        SB_IDLE: begin
          if (arb_grant) begin
            state_d  = SB_START;
            shift_d  = win_msg;
            par_d    = ^win_msg;
            gid_d    = arb_gid;
            tx_bit_d = 1'b1;
            frame_d  = 1'b1;
            busy_d   = 1'b1;
          end
        end
        SB_START: begin
          state_d   = SB_DATA;
          tx_bit_d  = shift_q[SB_MSG_WIDTH-1];
          frame_d   = 1'b1;
          shift_d   = shift_q << 1;
          bit_cnt_d = CNT_W'(SB_MSG_WIDTH - 1);
        end
        SB_DATA: begin
          frame_d = 1'b1;
          if (bit_cnt_q == '0) begin
            state_d  = SB_PARITY;
            tx_bit_d = par_q;
          end else begin
            tx_bit_d  = shift_q[SB_MSG_WIDTH-1];
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
        SB_PARITY: begin
          state_d   = SB_GAP;
          gap_cnt_d = 4'(GAP_CYCLES - 1);
        end
        SB_GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state_d = SB_IDLE;
            busy_d  = 1'b0;
            fe_d    = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = SB_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SB_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= 4'd0;
      par_q     <= 1'b0;
      tx_bit_q  <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      fe_q      <= 1'b0;
      gid_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      par_q     <= par_d;
      tx_bit_q  <= tx_bit_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      fe_q      <= fe_d;
      gid_q     <= gid_d;
    end
  end

  assign o_sb_tx_bit         = tx_bit_q;
  assign o_sb_tx_frame       = frame_q;
  assign o_busy_sideband     = busy_q;
  assign o_falling_edge_busy = fe_q;
  assign o_grant_id          = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_mbinit_sb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbinit_sb_tx_arbiter
// Description : Self-checking bench for the MBINIT sideband transmit stage.
//               Expected lane vectors {tx_bit, frame, busy, fe, grant_id}
//               are derived from planned frame start cycles and queued per
//               cycle; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbinit_sb_tx_arbiter;

  localparam int W   = 4;
  localparam int GAP = 2;
  localparam int NEVER = 100000;

  logic         CLK;
  logic         rst_n;
  logic         flush;
  logic [W-1:0] req0_msg;
  logic         req0_valid;
  logic [W-1:0] req1_msg;
  logic         req1_valid;
  logic         sb_tx_bit;
  logic         sb_tx_frame;
  logic         busy_sideband;
  logic         falling_edge_busy;
  logic         grant_id;

  int n_vec;
  int n_err;

  typedef struct {
    int           s;        // cycle the start bit appears
    bit           id;
    logic [W-1:0] msg;
    int           cut;      // first cycle the lane is forced idle
    bit           rst_cut;  // cut caused by reset (grant_id returns to 0)
  } frame_t;

  typedef struct {
    string      tag;
    logic [4:0] v;
  } exp_t;

  frame_t frames[$];
  exp_t   exp_q[$];

  mbinit_sb_tx_arbiter #(
    .SB_MSG_WIDTH (W),
    .GAP_CYCLES   (GAP)
  ) dut (
    .CLK                 (CLK),
    .rst_n               (rst_n),
    .i_flush             (flush),
    .i_req0_msg          (req0_msg),
    .i_req0_valid        (req0_valid),
    .i_req1_msg          (req1_msg),
    .i_req1_valid        (req1_valid),
    .o_sb_tx_bit         (sb_tx_bit),
    .o_sb_tx_frame       (sb_tx_frame),
    .o_busy_sideband     (busy_sideband),
    .o_falling_edge_busy (falling_edge_busy),
    .o_grant_id          (grant_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  wire [4:0] obs_vec = {sb_tx_bit, sb_tx_frame, busy_sideband, falling_edge_busy, grant_id};

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: {tx,frame,busy,fe,gid} got %b expected %b", tag, obs, expv);
    end
  endtask

  // Expected lane state in cycle c from the planned frame list.
  function automatic logic [4:0] exp_vec(input int c);
    logic   tx, fr, bz, fe, gid;
    frame_t f;
    int     o;
    tx = 1'b0; fr = 1'b0; bz = 1'b0; fe = 1'b0; gid = 1'b0;
    for (int i = 0; i < frames.size(); i++) begin
      f = frames[i];
      if (c >= f.s) gid = f.id;
      if (f.rst_cut && c >= f.cut) gid = 1'b0;
      if (c >= f.s && c < f.cut) begin
        o = c - f.s;
        if (o == 0) begin
          tx = 1'b1; fr = 1'b1; bz = 1'b1;
        end else if (o <= W) begin
          tx = f.msg[W-o]; fr = 1'b1; bz = 1'b1;
        end else if (o == W + 1) begin
          tx = ^f.msg; fr = 1'b1; bz = 1'b1;
        end else if (o <= W + 1 + GAP) begin
          bz = 1'b1;
        end else if (o == W + 2 + GAP) begin
          fe = 1'b1;
        end
      end
    end
    return {tx, fr, bz, fe, gid};
  endfunction

  // Per-test input schedule, indexed by cycle since reset release.
  task automatic drive(input int t, input int c);
    flush      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    case (t)
      1: begin
        req0_msg   = 4'b0001;
        req0_valid = (c >= 5 && c <= 14) || (c >= 20 && c <= 29);
      end
      2: begin
        req0_msg   = 4'b0001;
        req1_msg   = 4'b0010;
        req0_valid = (c >= 5 && c <= 14);
        req1_valid = (c >= 5 && c <= 23);
      end
      4: begin
        req1_msg   = 4'b0000;
        req1_valid = (c >= 5 && c <= 14);
      end
      5: begin
        req0_msg   = 4'b0001;
        req0_valid = (c >= 5 && c <= 12) || (c >= 16 && c <= 25);
        flush      = (c == 8);
      end
      6: begin
        req0_msg   = 4'b0001;
        req1_msg   = 4'b0010;
        req0_valid = (c >= 5 && c <= 19);
        req1_valid = (c >= 10 && c <= 28);
      end
      default: ;
    endcase
  endtask

  task automatic run_test(input int t, input int ncyc);
    rst_n      = 1'b0;
    flush      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (t == 6 && c == 10) rst_n = 1'b1;
      drive(t, c);
      exp_q.push_back('{$sformatf("t%0d_c%0d", t, c), exp_vec(c)});
      if (t == 6 && c == 8) begin
        #1 rst_n = 1'b0;
        #1 check("t6_async_rst", obs_vec, 5'b00000);
      end
      @(posedge CLK);
      #1;
    end
    frames.delete();
  endtask

  // Compare queued expectation against the lane mid-cycle.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.tag, obs_vec, e.v);
    end
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    req0_msg   = '0;
    req1_msg   = '0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single frame, held valid suppressed, re-raised request re-framed.
    frames.push_back('{6,  1'b0, 4'b0001, NEVER, 1'b0});
    frames.push_back('{21, 1'b0, 4'b0001, NEVER, 1'b0});
    run_test(1, 32);

    // Simultaneous requests: req0 first, req1 back-to-back at the fe cycle.
    frames.push_back('{6,  1'b0, 4'b0001, NEVER, 1'b0});
    frames.push_back('{15, 1'b1, 4'b0010, NEVER, 1'b0});
    run_test(2, 27);

    // Zero message is never sent.
    run_test(4, 18);

    // Flush mid-frame: no fe, no resend until valid toggles.
    frames.push_back('{6,  1'b0, 4'b0001, 9,     1'b0});
    frames.push_back('{17, 1'b0, 4'b0001, NEVER, 1'b0});
    run_test(5, 28);

    // Async reset mid-frame, then both request and req0 wins.
    frames.push_back('{6,  1'b0, 4'b0001, 8,     1'b1});
    frames.push_back('{11, 1'b0, 4'b0001, NEVER, 1'b0});
    frames.push_back('{20, 1'b1, 4'b0010, NEVER, 1'b0});
    run_test(6, 31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
